// File: rtl/event_readout_pkg.sv
// event_readout_pkg: field positions, command flags and ctrl packing shared by the readout scheduler
package event_readout_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam int NACK_UPPER_LSB = 20;
  localparam int NACK_LEN_LSB = 32;
  localparam int NACK_LEN_BITS = 11;
  localparam int NACK_FULL_BIT = 46;
  localparam int STS_TAG_BITS = 4;
  localparam int STS_ERR_LSB = 4;
  localparam int STS_ERR_MSB = 6;
  localparam int STS_OKAY_BIT = 7;
  localparam logic [31:0] CMD_FLAGS = 32'h4080_0000;
  function automatic logic [31:0] pack_ctrl(input logic [11:0] upper, input logic [18:0] bytes);
    return {upper, 1'b0, bytes};
  endfunction
endpackage

// File: rtl/readout_sync_fifo.sv
// readout_sync_fifo: first-word-fall-through synchronous fifo with full/empty flags
module readout_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             memclk,
  input  logic             memrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge memclk) begin
    if (memrst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge memclk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/event_readout_scheduler.sv
// event_readout_scheduler: arbitrates nack re-reads and credited completions into tagged DataMover commands
module event_readout_scheduler
  import event_readout_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ALLOW_BITS = 13,
  parameter int UPPER_BITS = 12,
  parameter int LOWER_BITS = 19,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    memclk,
  input  logic                    memrst,
  input  logic [LOWER_BITS-1:0]   cfg_start_offset_i,
  input  logic [LOWER_BITS-1:0]   cfg_btt_i,
  input  logic                    allow_i,
  output logic [ALLOW_BITS-1:0]   allow_count_o,
  input  logic [15:0]             s_cmpl_tdata,
  input  logic                    s_cmpl_tvalid,
  output logic                    s_cmpl_tready,
  input  logic [47:0]             s_nack_tdata,
  input  logic                    s_nack_tvalid,
  output logic                    s_nack_tready,
  output logic [40+ADDR_WIDTH-1:0] m_cmd_tdata,
  output logic                    m_cmd_tvalid,
  input  logic                    m_cmd_tready,
  input  logic [7:0]              s_sts_tdata,
  input  logic                    s_sts_tvalid,
  output logic                    s_sts_tready,
  output logic [31:0]             m_ctrl_tdata,
  output logic                    m_ctrl_tvalid,
  input  logic                    m_ctrl_tready,
  output logic [3:0]              outstanding_o,
  output logic                    sts_err_o,
  output logic                    tag_err_o
);
  state_t state, state_nx;
  logic [STS_TAG_BITS-1:0] tag, tag_head;
  logic [UPPER_BITS-1:0] upper, adm_upper;
  logic [LOWER_BITS-1:0] bytes, lower, adm_bytes, adm_lower;
  logic [31:0] ctrl_dout;
  logic src_nack, pend_nack, pend_cmpl, adm_full, admit;
  logic cmd_hs, cmpl_hs, sts_take, ctrl_full, ctrl_empty, tag_full, tag_empty;
  logic unused_bits;
  assign unused_bits = ^{s_cmpl_tdata[15:UPPER_BITS], s_nack_tdata[47], s_nack_tdata[45:43], s_nack_tdata[19], tag_full};
  assign m_cmd_tvalid = state == ISSUE;
  assign cmd_hs = m_cmd_tvalid && m_cmd_tready;
  assign cmpl_hs = cmd_hs && !src_nack;
  assign sts_take = s_sts_tvalid && !tag_empty;
  assign s_sts_tready = 1'b1;
  assign s_nack_tready = pend_nack;
  assign s_cmpl_tready = pend_cmpl;
  assign m_ctrl_tvalid = !ctrl_empty;
  assign m_ctrl_tdata = ctrl_empty ? '0 : ctrl_dout;
  assign m_cmd_tdata = m_cmd_tvalid ? {4'h0, tag, ADDR_WIDTH'({1'b0, upper, lower}), CMD_FLAGS | 32'(bytes)} : '0;
  always_comb begin
    adm_full = !s_nack_tvalid || s_nack_tdata[NACK_FULL_BIT];
    adm_upper = s_nack_tvalid ? s_nack_tdata[NACK_UPPER_LSB +: UPPER_BITS] : s_cmpl_tdata[UPPER_BITS-1:0];
    adm_bytes = adm_full ? cfg_btt_i : LOWER_BITS'({s_nack_tdata[NACK_LEN_LSB +: NACK_LEN_BITS], 3'b000});
    adm_lower = (adm_full ? '0 : s_nack_tdata[LOWER_BITS-1:0]) + cfg_start_offset_i;
    admit = state == IDLE && !pend_nack && !pend_cmpl && outstanding_o < 4'(MAX_OUTSTANDING) && !ctrl_full
      && (s_nack_tvalid || (s_cmpl_tvalid && allow_count_o != '0));
    state_nx = state == IDLE ? (admit ? ISSUE : IDLE) : (m_cmd_tready ? IDLE : ISSUE);
  end
  always_ff @(posedge memclk) begin
    if (memrst) begin
      state <= IDLE;
      allow_count_o <= '0;
      tag <= '0;
      outstanding_o <= '0;
      src_nack <= 1'b0;
      pend_nack <= 1'b0;
      pend_cmpl <= 1'b0;
      upper <= '0;
      bytes <= '0;
      lower <= '0;
      sts_err_o <= 1'b0;
      tag_err_o <= 1'b0;
    end else begin
      state <= state_nx;
      pend_nack <= cmd_hs && src_nack;
      pend_cmpl <= cmpl_hs;
      if (admit) begin
        src_nack <= s_nack_tvalid;
        upper <= adm_upper;
        bytes <= adm_bytes;
        lower <= adm_lower;
      end
      if (allow_i != cmpl_hs)
        allow_count_o <= allow_i ? (&allow_count_o ? allow_count_o : allow_count_o + 1'b1)
                                 : (allow_count_o == '0 ? '0 : allow_count_o - 1'b1);
      if (cmd_hs) tag <= tag + 1'b1;
      outstanding_o <= outstanding_o + 4'(cmd_hs) - 4'(sts_take);
      if (sts_take && tag_head != s_sts_tdata[STS_TAG_BITS-1:0]) tag_err_o <= 1'b1;
      if (sts_take && (!s_sts_tdata[STS_OKAY_BIT] || |s_sts_tdata[STS_ERR_MSB:STS_ERR_LSB])) sts_err_o <= 1'b1;
    end
  end
  readout_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_ctrl_fifo (
    .memclk(memclk),
    .memrst(memrst),
    .push(cmd_hs),
    .pop(m_ctrl_tready),
    .din(pack_ctrl(12'(upper), 19'(bytes))),
    .dout(ctrl_dout),
    .full(ctrl_full),
    .empty(ctrl_empty)
  );
  readout_sync_fifo #(.WIDTH(STS_TAG_BITS), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .memclk(memclk),
    .memrst(memrst),
    .push(cmd_hs),
    .pop(sts_take),
    .din(tag),
    .dout(tag_head),
    .full(tag_full),
    .empty(tag_empty)
  );
endmodule
